// File: rtl/mipi_tx_frame_sequencer.sv
// Frame/line timing generator for the MIPI CSI-2 TX interface: pulls packed pixel words
// from an upstream source, pads underruns, and sequences D-PHY ULPS around idle periods.
module mipi_tx_frame_sequencer #(
  parameter int HRES          = 640,
  parameter int PIX_PER_WORD  = 2,
  parameter int VRES          = 480,
  parameter int HS_W          = 8,
  parameter int HBP           = 16,
  parameter int HFP           = 16,
  parameter int VS_L          = 2,
  parameter int VBP_L         = 2,
  parameter int VFP_L         = 2,
  parameter int ULPS_DELAY    = 1024,
  parameter int ULPS_EXIT_CYC = 256
) (
  input  logic        tx_pixel_clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        pix_valid,
  input  logic [63:0] pix_data,
  output logic        pix_ready,
  output logic        mipi_tx_VSYNC,
  output logic        mipi_tx_HSYNC,
  output logic        mipi_tx_VALID,
  output logic [63:0] mipi_tx_DATA,
  output logic [15:0] mipi_tx_HRES,
  output logic [3:0]  mipi_tx_ULPS_ENTER,
  output logic [3:0]  mipi_tx_ULPS_EXIT,
  output logic        mipi_tx_ULPS_CLK_ENTER,
  output logic        mipi_tx_ULPS_CLK_EXIT,
  output logic        frame_done,
  output logic        underrun,
  output logic [15:0] frame_cnt
);

  localparam logic [15:0] L_HS       = 16'(HS_W);
  localparam logic [15:0] L_ACT_LO_H = 16'(HS_W + HBP);
  localparam logic [15:0] L_ACT_HI_H = 16'(HS_W + HBP + HRES / PIX_PER_WORD);
  localparam logic [15:0] L_LINE_END = 16'(HS_W + HBP + HRES / PIX_PER_WORD + HFP - 1);
  localparam logic [15:0] L_VS       = 16'(VS_L);
  localparam logic [15:0] L_ACT_LO_V = 16'(VS_L + VBP_L);
  localparam logic [15:0] L_ACT_HI_V = 16'(VS_L + VBP_L + VRES);
  localparam logic [15:0] L_LAST_LN  = 16'(VS_L + VBP_L + VRES + VFP_L - 1);
  localparam logic [15:0] L_IDLE_END = 16'(ULPS_DELAY - 1);
  localparam logic [15:0] L_WAKE_END = 16'(ULPS_EXIT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_ULPS, S_WAKE, S_FRAME} state_t;

  state_t      state_q, state_d;
  logic [15:0] idle_q, idle_d;
  logic [15:0] wake_q, wake_d;
  logic [15:0] h_q, h_d;
  logic [15:0] ln_q, ln_d;
  logic        frame_end;

  logic        vsync_q, hsync_q, valid_q, enter_q, exit_q, done_q, underrun_q;
  logic [63:0] data_q;
  logic [15:0] frame_cnt_q;

  logic frame_run, in_hs, in_act, active_line;

  assign frame_run   = (state_q == S_FRAME);
  assign in_hs       = (h_q < L_HS);
  assign in_act      = (h_q >= L_ACT_LO_H) && (h_q < L_ACT_HI_H);
  assign active_line = (ln_q >= L_ACT_LO_V) && (ln_q < L_ACT_HI_V);
  assign pix_ready   = frame_run && in_act && active_line;

  // NOTE: every next-state variable gets its hold value first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d   = state_q;
    idle_d    = idle_q;
    wake_d    = wake_q;
    h_d       = h_q;
    ln_d      = ln_q;
    frame_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_FRAME;
          h_d     = '0;
          ln_d    = '0;
          idle_d  = '0;
        end else if (idle_q == L_IDLE_END) begin
          state_d = S_ULPS;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + 16'd1;
        end
      end
      S_ULPS: begin
        if (enable) begin
          state_d = S_WAKE;
          wake_d  = '0;
        end
      end
      S_WAKE: begin
        // enable is deliberately ignored here: once woken, a frame always follows.
        if (wake_q == L_WAKE_END) begin
          state_d = S_FRAME;
          h_d     = '0;
          ln_d    = '0;
        end else begin
          wake_d = wake_q + 16'd1;
        end
      end
      default: begin
        if (h_q == L_LINE_END) begin
          h_d = '0;
          if (ln_q == L_LAST_LN) begin
            frame_end = 1'b1;
            ln_d      = '0;
            if (!enable) begin
              state_d = S_IDLE;
              idle_d  = '0;
            end
          end else begin
            ln_d = ln_q + 16'd1;
          end
        end else begin
          h_d = h_q + 16'd1;
        end
      end
    endcase
  end

  // NOTE: all clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge tx_pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idle_q  <= '0;
      wake_q  <= '0;
      h_q     <= '0;
      ln_q    <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      wake_q  <= wake_d;
      h_q     <= h_d;
      ln_q    <= ln_d;
    end
  end

  // One register stage for every TX-facing output keeps sync, data and status aligned.
  always_ff @(posedge tx_pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b0;
      hsync_q     <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      enter_q     <= 1'b0;
      exit_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      vsync_q <= frame_run && (ln_q < L_VS);
      hsync_q <= frame_run && in_hs;
      valid_q <= pix_ready;
      data_q  <= (pix_ready && pix_valid) ? pix_data : '0;
      enter_q <= (state_q == S_ULPS);
      exit_q  <= (state_q == S_WAKE);
      done_q  <= frame_end;
      if (pix_ready && !pix_valid) underrun_q <= 1'b1;
      if (frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign mipi_tx_VSYNC          = vsync_q;
  assign mipi_tx_HSYNC          = hsync_q;
  assign mipi_tx_VALID          = valid_q;
  assign mipi_tx_DATA           = data_q;
  assign mipi_tx_HRES           = 16'(HRES);
  assign mipi_tx_ULPS_ENTER     = {4{enter_q}};
  assign mipi_tx_ULPS_EXIT      = {4{exit_q}};
  assign mipi_tx_ULPS_CLK_ENTER = enter_q;
  assign mipi_tx_ULPS_CLK_EXIT  = exit_q;
  assign frame_done             = done_q;
  assign underrun               = underrun_q;
  assign frame_cnt              = frame_cnt_q;

endmodule
